// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
// Imported by the channel and top modules.
package clk_div_pkg;

    localparam int CNT_W_DEF   = 32;
    localparam int DEF_DIV_DEF = 5000000;

    // Channel-select width; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/div_channel.sv
// One divider channel: counter, active/pending divisor, divided clock and tick.
// A pending divisor only takes over at a wrap, while idle, or on sync.
module div_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             ld_we,
    input  logic [CNT_W-1:0] ld_div,
    output logic             pend_flag,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEF_DIV);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] div_active;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] div_m1;

    logic run;
    logic wrap;
    logic do_sync;
    logic do_wrap;
    logic do_idle;
    logic do_cnt;
    logic apply;

    assign div_m1  = div_active - ONE;
    assign run     = en && (div_active != '0);
    assign wrap    = (count == div_m1);

    assign do_sync = sync;
    assign do_wrap = !sync && run && wrap;
    assign do_idle = !sync && !run;
    assign do_cnt  = !sync && run && !wrap;

    // Only period boundaries may switch divisor, so clk_out never runts.
    assign apply   = pend_flag && (do_sync || do_wrap || do_idle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            div_active <= DIV_RST;
            pend_div   <= '0;
            pend_flag  <= 1'b0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
        end else begin
            tick <= 1'b0;
            unique case (1'b1)
                do_sync: begin
                    count   <= '0;
                    clk_out <= 1'b0;
                end
                do_wrap: begin
                    count   <= '0;
                    clk_out <= ~clk_out;
                    tick    <= 1'b1;
                end
                do_idle: begin
                    if (pend_flag) begin
                        count <= '0;
                    end
                end
                do_cnt: begin
                    count <= count + ONE;
                end
                default: begin
                end
            endcase
            if (apply) begin
                div_active <= pend_div;
                pend_flag  <= 1'b0;
            end
            // Handshake only admits a load while nothing is pending.
            if (ld_we) begin
                pend_div  <= ld_div;
                pend_flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_channel_clock_divider.sv
// N_CH independent dividers with a shared divisor-load port.
// Top decodes the load channel, muxes ld_ready and gathers outputs.
module multi_channel_clock_divider
    import clk_div_pkg::*;
#(
    parameter  int N_CH    = 4,
    parameter  int CNT_W   = CNT_W_DEF,
    parameter  int DEF_DIV = DEF_DIV_DEF,
    localparam int CH_W    = clog2_min1(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic             ld_valid,
    input  logic [CH_W-1:0]  ld_ch,
    input  logic [CNT_W-1:0] ld_div,
    output logic             ld_ready,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick
);

    logic [N_CH-1:0] pend_flag;
    logic [N_CH-1:0] ld_we;

    // Out-of-range channels stay ready so such loads are accepted and dropped.
    always_comb begin
        ld_ready = 1'b1;
        ld_we    = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ld_ch == CH_W'(i)) begin
                ld_ready = ~pend_flag[i];
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            ld_we[i] = ld_valid && ld_ready && (ld_ch == CH_W'(i));
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        div_channel #(
            .CNT_W  (CNT_W),
            .DEF_DIV(DEF_DIV)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
            .sync     (sync),
            .ld_we    (ld_we[i]),
            .ld_div   (ld_div),
            .pend_flag(pend_flag[i]),
            .clk_out  (clk_out[i]),
            .tick     (tick[i])
        );
    end

endmodule
